// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit that produces the HI/LO results for the
// multicycle MIPS datapath. One shared shift engine handles all four
// operations, retiring one bit per cycle through a start/busy/done handshake.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 4)
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   synchronous active-high reset
//   Start    in   request an operation (sampled only while idle)
//   Op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A        in   multiplicand / dividend (rs)
//   B        in   multiplier / divisor (rt)
//   Busy     out  high whenever the unit is not idle
//   Done     out  one-cycle completion pulse
//   DivZero  out  last accepted operation was a divide by zero
//   Hi       out  product upper half, or remainder
//   Lo       out  product lower half, or quotient
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Conditional two's-complement negation, used both for taking operand
  // magnitudes and for restoring result signs.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             n);
    cond_neg = n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic               n);
    cond_neg_2w = n ? (~x + 1'b1) : x;
  endfunction

  // Control and result registers (reset)
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             dz_q,    dz_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  // Datapath registers (no reset; always loaded on accept before use)
  logic               div_q,   div_d;
  logic               negp_q,  negp_d;   // product / quotient sign
  logic               negr_q,  negr_d;   // remainder sign
  logic [WIDTH-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q,   acc_d;    // product, or dividend/quotient in low half
  logic [WIDTH:0]     rem_q,   rem_d;    // partial remainder

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Shift-add step: add the multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right, keeping
  // the carry as the new MSB.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  // Restoring divide step: shift the next dividend bit into the remainder
  // and trial-subtract the divisor; a clear sign bit means the subtraction
  // fits and the quotient bit is 1.
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, mcand_q};

  assign a_neg = ~Op[0] & A[WIDTH-1];
  assign b_neg = ~Op[0] & B[WIDTH-1];
  assign a_mag = cond_neg(A, a_neg);
  assign b_mag = cond_neg(B, b_neg);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          busy_d = 1'b1;
          dz_d   = 1'b0;
          div_d  = Op[1];
          if (Op[1] && (B == '0)) begin
            // Divide by zero finishes immediately and leaves Hi/Lo alone.
            state_d = S_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = S_CALC;
            cnt_d   = '0;
            negp_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            rem_d   = '0;
            if (Op[1]) begin
              mcand_d = b_mag;
              acc_d   = {{WIDTH{1'b0}}, a_mag};
            end else begin
              mcand_d = a_mag;
              acc_d   = {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
          rem_d = div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (div_q) begin
          lo_d = cond_neg(acc_q[WIDTH-1:0], negp_q);
          hi_d = cond_neg(rem_q[WIDTH-1:0], negr_q);
        end else begin
          {hi_d, lo_d} = cond_neg_2w(acc_q, negp_q);
        end
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      default: begin  // S_DONE
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge Clk) begin
    div_q   <= div_d;
    negp_q  <= negp_d;
    negr_q  <= negr_d;
    mcand_q <= mcand_d;
    acc_q   <= acc_d;
    rem_q   <= rem_d;
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        Clk;
  // 32-bit instance
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;
  // 8-bit instance
  logic        rst8, start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int tests = 0;
  int fails = 0;
  logic [31:0] ehi [2];
  logic [31:0] elo [2];

  muldiv_unit #(.WIDTH(32)) dut32 (
    .Clk(Clk), .Reset(rst), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .Done(done), .DivZero(dz), .Hi(hi), .Lo(lo));

  muldiv_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(rst8), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .DivZero(dz8), .Hi(hi8), .Lo(lo8));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on sign/zero-extended operands.
  // SV '/' and '%' truncate toward zero with the remainder taking the
  // dividend's sign, matching MIPS semantics.
  function automatic void ref_op(input int w, input logic [1:0] o,
                                 input logic [31:0] x, input logic [31:0] y,
                                 inout logic [31:0] rhi, inout logic [31:0] rlo,
                                 output logic rdz);
    logic [63:0] mask, p, t;
    longint ea, eb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ea = longint'({32'd0, x} & mask);
    eb = longint'({32'd0, y} & mask);
    if (!o[0] && x[w-1]) ea = ea - (longint'(1) << w);
    if (!o[0] && y[w-1]) eb = eb - (longint'(1) << w);
    rdz = 1'b0;
    if (!o[1]) begin
      p = ea * eb;
      t = (p >> w) & mask;
      rhi = t[31:0];
      t = p & mask;
      rlo = t[31:0];
    end else if (eb == 0) begin
      rdz = 1'b1;
    end else begin
      q = ea / eb;
      r = ea % eb;
      t = q & mask;
      rlo = t[31:0];
      t = r & mask;
      rhi = t[31:0];
    end
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m, v;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = m;
      3: v = 32'd1 << (w - 1);
      4: v = m >> 1;
      default: v = $urandom & m;
    endcase
    return v;
  endfunction

  // Issue one operation and wait (bounded) for Done. Operands are scrambled
  // right after the accept edge. lat counts edges from accept through the
  // edge that raises Done; bc counts cycles Busy was seen high meanwhile.
  task automatic op_run(input int w, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int lat, output int bc);
    @(negedge Clk);
    if (w == 32) begin start = 1'b1; op = o; a = x; b = y; end
    else begin start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
    lat = 0;
    bc = 0;
    do begin
      @(posedge Clk); #1;
      start = 1'b0; start8 = 1'b0;
      if (w == 32) begin op = 2'($urandom); a = $urandom; b = $urandom; end
      else begin op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
      lat++;
      if ((w == 32) ? busy : busy8) bc++;
    end while (!((w == 32) ? done : done8) && lat < 100);
  endtask

  task automatic run(input string tag, input int w, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y);
    int lat, bc, idx, elat;
    logic edz;
    logic [31:0] th, tl, ohi, olo;
    logic odz, obusy, odone;
    idx = (w == 8) ? 1 : 0;
    op_run(w, o, x, y, lat, bc);
    th = ehi[idx]; tl = elo[idx];
    ref_op(w, o, x, y, th, tl, edz);
    ehi[idx] = th; elo[idx] = tl;
    elat = edz ? 1 : w + 2;
    ohi = (w == 32) ? hi : {24'd0, hi8};
    olo = (w == 32) ? lo : {24'd0, lo8};
    odz = (w == 32) ? dz : dz8;
    check({tag, ".latency"}, lat, elat);
    check({tag, ".busy_cycles"}, bc, elat);
    check({tag, ".hi"}, ohi, th);
    check({tag, ".lo"}, olo, tl);
    check({tag, ".divzero"}, {31'd0, odz}, {31'd0, edz});
    @(posedge Clk); #1;
    obusy = (w == 32) ? busy : busy8;
    odone = (w == 32) ? done : done8;
    check({tag, ".idle_after"}, {30'd0, obusy, odone}, 32'd0);
  endtask

  initial begin
    int lat, n1, n2, nd;
    logic [31:0] th, tl;
    logic tdz;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    rst8 = 1'b1; start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    ehi[0] = '0; elo[0] = '0; ehi[1] = '0; elo[1] = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset.ctl32", {29'd0, busy, done, dz}, 32'd0);
    check("reset.hi32", hi, 32'd0);
    check("reset.lo32", lo, 32'd0);
    check("reset.ctl8", {29'd0, busy8, done8, dz8}, 32'd0);
    check("reset.hilo8", {16'd0, hi8, lo8}, 32'd0);
    rst = 1'b0; rst8 = 1'b0;

    // Directed 32-bit cases
    run("mult_m3x5", 32, 2'b00, 32'hFFFF_FFFD, 32'd5);
    check("mult_m3x5.hi_const", hi, 32'hFFFF_FFFF);
    check("mult_m3x5.lo_const", lo, 32'hFFFF_FFF1);
    run("multu_ffff", 32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_ffff.hi_const", hi, 32'hFFFF_FFFE);
    check("multu_ffff.lo_const", lo, 32'h0000_0001);
    run("mult_m1xm1", 32, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult_m1xm1.hilo_const", hi | (lo ^ 32'd1), 32'd0);
    run("div_m7_2", 32, 2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2.lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_2.hi_const", hi, 32'hFFFF_FFFF);
    run("divu_7_2", 32, 2'b11, 32'd7, 32'd2);
    check("divu_7_2.lohi_const", {lo[15:0], hi[15:0]}, 32'h0003_0001);
    run("div_7_m2", 32, 2'b10, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2.lo_const", lo, 32'hFFFF_FFFD);
    run("mult_2x3", 32, 2'b00, 32'd2, 32'd3);
    run("div_5_0", 32, 2'b10, 32'd5, 32'd0);
    check("div_5_0.lo_const", lo, 32'd6);
    check("div_5_0.dz_const", {31'd0, dz}, 32'd1);
    run("mult_after_dz", 32, 2'b00, 32'd9, 32'd9);
    run("div_ovf", 32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf.lo_const", lo, 32'h8000_0000);
    run("mult_min_min", 32, 2'b00, 32'h8000_0000, 32'h8000_0000);
    check("mult_min_min.hi_const", hi, 32'h4000_0000);
    run("divu_0_x", 32, 2'b11, 32'd0, 32'd0);

    // Start pulsed mid-operation must be ignored
    @(negedge Clk);
    start = 1'b1; op = 2'b00; a = 32'd123457; b = 32'hFFFF_0001;
    lat = 0;
    do begin
      @(posedge Clk); #1;
      start = 1'b0;
      lat++;
      if (lat == 10) begin start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd7; end
    end while (!done && lat < 100);
    th = ehi[0]; tl = elo[0];
    ref_op(32, 2'b00, 32'd123457, 32'hFFFF_0001, th, tl, tdz);
    ehi[0] = th; elo[0] = tl;
    check("midstart.latency", lat, 32'd34);
    check("midstart.hi", hi, th);
    check("midstart.lo", lo, tl);
    @(posedge Clk); #1;
    check("midstart.idle_after", {30'd0, busy, done}, 32'd0);

    // Reset during a divide aborts it
    run("pre_reset_div", 32, 2'b10, 32'hFFFF_FFF9, 32'd2);
    @(negedge Clk);
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FC18; b = 32'd3;
    repeat (20) begin @(posedge Clk); #1; start = 1'b0; end
    @(negedge Clk); rst = 1'b1;
    @(posedge Clk); #1; rst = 1'b0;
    check("abort.busy_done", {30'd0, busy, done}, 32'd0);
    check("abort.hi", hi, 32'd0);
    check("abort.lo", lo, 32'd0);
    ehi[0] = '0; elo[0] = '0;
    nd = 0;
    repeat (40) begin @(posedge Clk); #1; if (done || busy) nd++; end
    check("abort.no_done", nd, 32'd0);
    run("post_reset", 32, 2'b01, 32'd1000, 32'd1000);

    // WIDTH=8 directed
    run("w8_mult_min", 8, 2'b00, 32'h80, 32'h80);
    check("w8_mult_min.hilo_const", {hi8, lo8}, 32'h4000);
    run("w8_divu", 8, 2'b11, 32'd200, 32'd7);
    check("w8_divu.lohi_const", {lo8, hi8}, 32'h1C04);
    run("w8_div_ovf", 8, 2'b10, 32'h80, 32'hFF);
    run("w8_div0", 8, 2'b11, 32'd5, 32'd0);

    // Back-to-back: Start held through DONE, operands change before re-accept
    @(negedge Clk);
    start8 = 1'b1; op8 = 2'b01; a8 = 8'd13; b8 = 8'd11;
    n1 = 0;
    do begin @(posedge Clk); #1; n1++; end while (!done8 && n1 < 100);
    th = ehi[1]; tl = elo[1];
    ref_op(8, 2'b01, 32'd13, 32'd11, th, tl, tdz);
    check("b2b.first_latency", n1, 32'd10);
    check("b2b.first_hilo", {16'd0, hi8, lo8}, {16'd0, th[7:0], tl[7:0]});
    op8 = 2'b10; a8 = 8'hE7; b8 = 8'h05;
    n2 = 0;
    do begin @(posedge Clk); #1; n2++; end while (!done8 && n2 < 100);
    start8 = 1'b0;
    ref_op(8, 2'b10, 32'hE7, 32'h05, th, tl, tdz);
    ehi[1] = th; elo[1] = tl;
    check("b2b.interval", n2, 32'd11);
    check("b2b.second_hilo", {16'd0, hi8, lo8}, {16'd0, th[7:0], tl[7:0]});
    @(posedge Clk); #1;
    check("b2b.idle_after", {30'd0, busy8, done8}, 32'd0);

    // Randomized
    for (int i = 0; i < 40; i++) run("rand32", 32, 2'($urandom), pick(32), pick(32));
    for (int i = 0; i < 30; i++) run("rand8", 8, 2'($urandom), pick(8), pick(8));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
